// File: rtl/lut_logic_array.sv
// Programmable bitwise logic engine: LANES independent K-input look-up lanes,
// one registered data stage with valid/ready, and drained run-time reconfiguration.
module lut_logic_array #(
  parameter int K = 2,
  parameter int LANES = 4,
  parameter logic [(1<<K)-1:0] FUNC_RESET = '0,
  localparam int FW = 1 << K,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*K-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES-1:0]     out_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [LW-1:0]        cfg_lane,
  input  logic                 cfg_bcast,
  input  logic [FW-1:0]        cfg_func
);

  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;

  state_t           state;
  logic [FW-1:0]    func_q [LANES];
  logic [LANES-1:0] result_p0;
  logic [LANES-1:0] data_p1;
  logic             vld_p1;
  logic             fire;

  function automatic logic lut_pick(input logic [FW-1:0] f, input logic [K-1:0] sel);
    return f[sel];
  endfunction

  // Input acceptance is blocked outside RUN so a config never lands mid-stream.
  always_comb begin
    in_ready = (state == RUN) && (!vld_p1 || out_ready);
    fire     = in_valid && in_ready;
  end

  always_comb begin
    result_p0 = '0;
    for (int i = 0; i < LANES; i++)
      result_p0[i] = lut_pick(func_q[i], in_data[i*K +: K]);
  end

  // ---- stage p0 -> p1 : registered result word ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (fire) begin
      vld_p1  <= 1'b1;
      data_p1 <= result_p0;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cfg_ready <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          cfg_ready <= 1'b0;
          if (cfg_valid) state <= DRAIN;
        end
        DRAIN: begin
          if (!vld_p1 || out_ready) begin
            state     <= APPLY;
            cfg_ready <= 1'b1;
          end
        end
        APPLY: begin
          state     <= RUN;
          cfg_ready <= 1'b0;
        end
        default: begin
          state     <= RUN;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  // An out-of-range lane index matches no lane, so nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) func_q[i] <= FUNC_RESET;
    end else if (state == APPLY) begin
      for (int i = 0; i < LANES; i++)
        if (cfg_bcast || (cfg_lane == LW'(i))) func_q[i] <= cfg_func;
    end
  end

endmodule

// File: tb/tb_lut_logic_array.sv
// Bench for lut_logic_array: K=2/LANES=4 instance driven against a queue scoreboard,
// plus a K=3/LANES=1 instance exercising the majority function and reset recovery.
module tb_lut_logic_array;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data;
  logic [3:0] a_out_data;
  logic       a_cfg_valid, a_cfg_ready, a_cfg_bcast;
  logic [1:0] a_cfg_lane;
  logic [3:0] a_cfg_func;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0] b_in_data;
  logic [0:0] b_out_data;
  logic       b_cfg_valid, b_cfg_ready, b_cfg_bcast;
  logic [0:0] b_cfg_lane;
  logic [7:0] b_cfg_func;

  lut_logic_array #(.K(2), .LANES(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready), .cfg_lane(a_cfg_lane),
    .cfg_bcast(a_cfg_bcast), .cfg_func(a_cfg_func)
  );

  lut_logic_array #(.K(3), .LANES(1)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_lane(b_cfg_lane),
    .cfg_bcast(b_cfg_bcast), .cfg_func(b_cfg_func)
  );

  int checks = 0;
  int errors = 0;
  int cfg_seen = 0;
  logic [3:0] fa [4];
  logic [3:0] q [$];
  logic [0:0] bq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_a(input logic [7:0] d);
    logic [3:0] r;
    logic [1:0] sel;
    for (int i = 0; i < 4; i++) begin
      sel  = d[i*2 +: 2];
      r[i] = fa[i][sel];
    end
    return r;
  endfunction

  function automatic logic [0:0] maj3(input logic [2:0] d);
    return 1'((32'(d[0]) + 32'(d[1]) + 32'(d[2])) >= 2);
  endfunction

  // One clock of instance A: sample after inputs settle, update scoreboard/model.
  task automatic step();
    logic [3:0] e;
    #1;
    if (a_cfg_ready) begin
      for (int i = 0; i < 4; i++)
        if (a_cfg_bcast || a_cfg_lane == 2'(i)) fa[i] = a_cfg_func;
      cfg_seen++;
    end
    if (a_out_valid && a_out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 32'(a_out_data), 32'hFFFF);
      else begin
        e = q.pop_front();
        chk("out_data", 32'(a_out_data), 32'(e));
      end
    end
    if (a_in_valid && a_in_ready) q.push_back(model_a(a_in_data));
    @(negedge clk);
  endtask

  task automatic flush();
    int n = 0;
    a_out_ready = 1'b1;
    while (q.size() > 0 && n < 20) begin step(); n++; end
    chk("flush_empty", 32'(q.size()), 0);
  endtask

  task automatic send(input logic [7:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic cfg_a(input logic bc, input logic [1:0] lane, input logic [3:0] f);
    int n = 0;
    int s0 = cfg_seen;
    a_cfg_valid = 1'b1; a_cfg_bcast = bc; a_cfg_lane = lane; a_cfg_func = f;
    while (cfg_seen == s0 && n < 20) begin step(); n++; end
    a_cfg_valid = 1'b0;
    chk("cfg_cycles", 32'(n), 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 1; a_cfg_valid = 0;
    a_cfg_bcast = 0; a_cfg_lane = 0; a_cfg_func = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 1; b_cfg_valid = 0;
    b_cfg_bcast = 0; b_cfg_lane = 0; b_cfg_func = 0;
    for (int i = 0; i < 4; i++) fa[i] = 4'h0;
    @(negedge clk); @(negedge clk);
    #1 chk("rst_in_ready", 32'(a_in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_out_data", 32'(a_out_data), 0);
    chk("rst_in_ready2", 32'(a_in_ready), 1);
    chk("rst_cfg_ready", 32'(a_cfg_ready), 0);

    // Reset function is all-zero.
    send(8'b11_10_01_00);
    flush();
    chk("reset_func_word", 32'(a_out_data), 0);

    // Broadcast XOR.
    cfg_a(1'b1, 2'd0, 4'b0110);
    send(8'b11_10_01_00);
    flush();
    chk("xor_word", 32'(a_out_data), 32'b0110);

    // Per-lane AND / OR / NAND / XOR, two words back to back.
    cfg_a(1'b0, 2'd0, 4'b1000);
    cfg_a(1'b0, 2'd1, 4'b1110);
    cfg_a(1'b0, 2'd2, 4'b0111);
    cfg_a(1'b0, 2'd3, 4'b0110);
    a_in_valid = 1'b1; a_in_data = 8'b01_01_01_01;
    step();
    a_in_data = 8'b11_11_11_11;
    #1 chk("mixed_01_word", 32'(a_out_data), 32'b1110);
    step();
    a_in_valid = 1'b0;
    #1 chk("mixed_11_word", 32'(a_out_data), 32'b0011);
    flush();

    // Backpressure: first word held, no acceptance, then full-rate drain.
    a_out_ready = 1'b0;
    send(8'h1B);
    a_in_valid = 1'b1; a_in_data = 8'hE4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(a_in_ready), 0);
      chk("bp_out_valid", 32'(a_out_valid), 1);
      chk("bp_hold", 32'(a_out_data), 32'(q[0]));
      step();
    end
    a_out_ready = 1'b1;
    step();
    a_in_data = 8'h72;
    #1 chk("thru_valid1", 32'(a_out_valid), 1);
    step();
    a_in_valid = 1'b0;
    #1 chk("thru_valid2", 32'(a_out_valid), 1);
    step();
    chk("bp_queue_empty", 32'(q.size()), 0);
    #1 chk("bp_idle", 32'(a_out_valid), 0);

    // Config during a stalled word; same-cycle input still accepted.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h55;
    a_cfg_valid = 1'b1; a_cfg_bcast = 1'b1; a_cfg_func = 4'b1001;
    #1 chk("cfg_same_cycle_ready", 32'(a_in_ready), 1);
    step();
    a_in_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_in_ready", 32'(a_in_ready), 0);
      chk("drain_cfg_ready", 32'(a_cfg_ready), 0);
      step();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    #1 chk("drain_exit_cfg_ready", 32'(a_cfg_ready), 0);
    step();
    #1 chk("apply_cfg_ready", 32'(a_cfg_ready), 1);
    step();
    a_cfg_valid = 1'b0;
    send(8'b11_10_01_00);
    flush();
    chk("xnor_word", 32'(a_out_data), 32'b1001);

    // Reset while draining.
    a_out_ready = 1'b0;
    send(8'h00);
    a_cfg_valid = 1'b1; a_cfg_func = 4'b1111;
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(a_out_valid), 0);
    chk("rst_mid_cfg_ready", 32'(a_cfg_ready), 0);
    q.delete();
    for (int i = 0; i < 4; i++) fa[i] = 4'h0;
    @(negedge clk); @(negedge clk);
    a_cfg_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("post_rst_cfg_ready", 32'(a_cfg_ready), 0);
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    send(8'hFF);
    flush();
    chk("post_rst_func", 32'(a_out_data), 0);

    // K=3, LANES=1: majority table.
    b_cfg_valid = 1'b1; b_cfg_lane = 1'b0; b_cfg_func = 8'b1110_1000;
    n = 0;
    #1;
    while (!b_cfg_ready && n < 10) begin @(negedge clk); #1; n++; end
    chk("b_cfg_done", 32'(b_cfg_ready), 1);
    @(negedge clk);
    b_cfg_valid = 1'b0;
    b_in_valid = 1'b1; b_in_data = 3'b011; bq.push_back(maj3(3'b011));
    @(negedge clk);
    b_in_data = 3'b100; bq.push_back(maj3(3'b100));
    #1;
    chk("b_valid1", 32'(b_out_valid), 1);
    chk("b_maj_011", 32'(b_out_data), 32'(bq.pop_front()));
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    chk("b_maj_100", 32'(b_out_data), 32'(bq.pop_front()));

    // K=3 reset mid-drain reverts to the all-zero table.
    b_out_ready = 1'b0;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = 3'b111;
    @(negedge clk);
    b_in_valid = 1'b0;
    b_cfg_valid = 1'b1; b_cfg_func = 8'hFF;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("b_rst_out_valid", 32'(b_out_valid), 0);
    chk("b_rst_cfg_ready", 32'(b_cfg_ready), 0);
    @(negedge clk);
    b_cfg_valid = 1'b0;
    rst = 1'b0;
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 3'b011;
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    chk("b_post_rst_valid", 32'(b_out_valid), 1);
    chk("b_post_rst_func", 32'(b_out_data), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
